// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: IF front end, synchronous imem plus {pc, instr} queue.
// Define FETCH_PERF_CNT_EN to add the fetch_count / stall_count outputs.
module fetch_queue_unit #(
    parameter int                ADDR_W     = 64,
    parameter int                IMEM_DEPTH = 256,
    parameter int                QDEPTH     = 2,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      stall,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic                      out_valid,
    output logic [31:0]               out_instr,
    output logic [ADDR_W-1:0]         out_pc,
    output logic [ADDR_W-1:0]         pc,
    output logic [$clog2(QDEPTH):0]   queue_count
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]               fetch_count,
    output logic [31:0]               stall_count
`endif
);

    localparam int IW = $clog2(IMEM_DEPTH);
    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    localparam logic [31:0]       NOP  = 32'h0000_0013;
    localparam logic [CW-1:0]     QMAX = CW'(QDEPTH);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    typedef enum logic {
        FETCH,
        HOLD
    } state_t;

    state_t state;
    state_t state_n;

    logic [31:0]       instr_mem [IMEM_DEPTH];

    logic [31:0]       q_instr [QDEPTH];
    logic [ADDR_W-1:0] q_pc    [QDEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr_n;

    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic [31:0]       rdata;

    logic              push;
    logic              pop;
    logic              issue;
    logic [CW-1:0]     left;
    logic [CW-1:0]     occ;

    logic [31:0]       head_instr;
    logic [ADDR_W-1:0] head_pc;

    logic [IW-1:0]     rd_idx;
    logic [ADDR_W-1:0] redir_tgt;

    assign rd_idx    = pc[IW+1:2];
    assign redir_tgt = redirect_pc & ALIGN_MASK;

    // Handshake terms: response push, head pop and post-edge occupancy.
    always_comb begin
        push     = inflight && !redirect_valid;
        pop      = out_valid && !stall && !redirect_valid;
        left     = queue_count - CW'(pop);
        occ      = left + CW'(inflight);
        rd_ptr_n = rd_ptr + PW'(pop);
    end

    // Fetch FSM: decide whether to issue and whether the queue is booked out.
    always_comb begin
        state_n = state;
        issue   = 1'b0;
        unique case (state)
            FETCH: issue = (occ < QMAX);
            HOLD:  issue = pop;
        endcase
        if (redirect_valid) begin
            issue   = 1'b0;
            state_n = FETCH;
        end else if ((occ + CW'(issue)) == QMAX) begin
            state_n = HOLD;
        end else begin
            state_n = FETCH;
        end
    end

    // Head entry as it will look after this edge.
    always_comb begin
        head_instr = NOP;
        head_pc    = '0;
        if (left != '0) begin
            head_instr = q_instr[rd_ptr_n];
            head_pc    = q_pc[rd_ptr_n];
        end else if (push) begin
            head_instr = rdata;
            head_pc    = inflight_pc;
        end
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_n;
        end
    end

    // Fetch PC and the single outstanding request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_valid) begin
            pc       <= redir_tgt;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + ADDR_W'(4);
                inflight_pc <= pc;
            end
        end
    end

    // Synchronous instruction memory read, kept reset-free for RAM mapping.
    always_ff @(posedge clock) begin
        if (issue) begin
            rdata <= instr_mem[rd_idx];
        end
    end

    // Queue storage; validity is tracked by the pointers and count.
    always_ff @(posedge clock) begin
        if (push) begin
            q_instr[wr_ptr] <= rdata;
            q_pc[wr_ptr]    <= inflight_pc;
        end
    end

    // Queue pointers, occupancy and the registered head outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
            out_valid   <= 1'b0;
            out_instr   <= NOP;
            out_pc      <= '0;
        end else if (redirect_valid) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            queue_count <= '0;
            out_valid   <= 1'b0;
            out_instr   <= NOP;
            out_pc      <= '0;
        end else begin
            rd_ptr      <= rd_ptr_n;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            queue_count <= occ;
            out_valid   <= (occ != '0);
            out_instr   <= head_instr;
            out_pc      <= head_pc;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    // Saturating counters for pushes and decode stall cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (push && (fetch_count != '1)) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (out_valid && stall && (stall_count != '1)) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: queue-level reference model plus directed scenarios.
// Outputs are compared against the model on every falling clock edge.
module tb_fetch_queue_unit;

    localparam int QD = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic [63:0] pc;
    logic [1:0]  queue_count;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    fetch_queue_unit dut (
        .clock          (clock),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .pc             (pc),
        .queue_count    (queue_count)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count    (fetch_count),
        .stall_count    (stall_count)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: fetch pc, buffered pcs and the pending request.
    logic [31:0] m_mem [256];
    logic [63:0] m_pc = '0;
    logic [63:0] m_q[$];
    logic [63:0] m_pend[$];
    int          m_free;
    bit          m_take;
    logic [31:0] m_fc = '0;
    logic [31:0] m_sc = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_pc = '0;
            m_q.delete();
            m_pend.delete();
            m_fc = '0;
            m_sc = '0;
        end else begin
            if (m_q.size() != 0 && stall) m_sc = m_sc + 1;
            if (redirect_valid) begin
                m_q.delete();
                m_pend.delete();
                m_pc = redirect_pc & ~64'h3;
            end else begin
                m_take = (m_q.size() != 0) && !stall;
                if (m_take) void'(m_q.pop_front());
                m_free = QD - m_q.size() - m_pend.size();
                foreach (m_pend[i]) begin
                    m_q.push_back(m_pend[i]);
                    m_fc = m_fc + 1;
                end
                m_pend.delete();
                if (m_free > 0) begin
                    m_pend.push_back(m_pc);
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    end

    logic [63:0] e_pc;
    logic [7:0]  e_idx;
    logic [31:0] e_instr;

    // Cycle compare of all outputs against the model.
    always @(negedge clock) begin
        if (cmp_on) begin
            if (m_q.size() != 0) begin
                e_pc    = m_q[0];
                e_idx   = e_pc[9:2];
                e_instr = m_mem[e_idx];
            end else begin
                e_pc    = '0;
                e_instr = NOP;
            end
            chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
            chk("out_pc", out_pc, e_pc);
            chk("out_instr", 64'(out_instr), 64'(e_instr));
            chk("pc", pc, m_pc);
            chk("queue_count", 64'(queue_count), 64'(m_q.size()));
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_count", 64'(fetch_count), 64'(m_fc));
            chk("stall_count", 64'(stall_count), 64'(m_sc));
`endif
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [15:0] pat = 16'b0110_1110_0010_1101;

    initial begin
        for (int k = 0; k < 256; k++) begin
            m_mem[k] = 32'h0010_0093 + (k << 20);
            dut.instr_mem[k] = 32'h0010_0093 + (k << 20);
        end
        #1 reset = 1'b0;
        #1 cmp_on = 1'b1;
        cyc(2);
        reset = 1'b1;

        // latency after reset release
        cyc(1);
        chk("lat_valid_e1", 64'(out_valid), 64'd0);
        chk("lat_pc_e1", pc, 64'h4);
        cyc(1);
        chk("lat_valid_e2", 64'(out_valid), 64'd1);
        chk("lat_pc0", out_pc, 64'h0);
        chk("lat_instr0", 64'(out_instr), 64'h0010_0093);
        cyc(1);
        chk("seq_pc4", out_pc, 64'h4);
        chk("seq_instr1", 64'(out_instr), 64'h0020_0093);
        cyc(5);

        // back-pressure
        stall = 1'b1;
        cyc(5);
        chk("bp_count", 64'(queue_count), 64'd2);
        chk("bp_pc", pc, 64'h20);
        chk("bp_head", out_pc, 64'h18);
        chk("bp_instr", 64'(out_instr), 64'h0070_0093);
        stall = 1'b0;
        cyc(3);

        // redirect with a full queue
        stall = 1'b1;
        cyc(3);
        stall = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'h40;
        cyc(1);
        redirect_valid = 1'b0;
        chk("rd_valid", 64'(out_valid), 64'd0);
        chk("rd_count", 64'(queue_count), 64'd0);
        chk("rd_pc", pc, 64'h40);
        cyc(2);
        chk("rd_tgt_pc", out_pc, 64'h40);
        chk("rd_tgt_instr", 64'(out_instr), 64'h0110_0093);
        cyc(2);

        // redirect during stall, misaligned target
        stall = 1'b1;
        cyc(2);
        redirect_valid = 1'b1;
        redirect_pc = 64'h4E;
        cyc(1);
        redirect_valid = 1'b0;
        chk("mis_pc", pc, 64'h4C);
        chk("mis_count", 64'(queue_count), 64'd0);
        cyc(3);
        stall = 1'b0;
        cyc(2);

        // imem index wrap
        redirect_valid = 1'b1;
        redirect_pc = 64'h3FC;
        cyc(1);
        redirect_valid = 1'b0;
        cyc(2);
        chk("wrap_pc255", out_pc, 64'h3FC);
        chk("wrap_instr255", 64'(out_instr), 64'h1000_0093);
        cyc(1);
        chk("wrap_pc400", out_pc, 64'h400);
        chk("wrap_instr0", 64'(out_instr), 64'h0010_0093);

        // irregular stall pattern
        for (int i = 0; i < 24; i++) begin
            stall = pat[i % 16];
            cyc(1);
        end
        stall = 1'b1;
        cyc(1);
        stall = 1'b0;
        cyc(2);

        // async reset between edges
        @(posedge clock);
        #2 reset = 1'b0;
        #1;
        chk("ar_valid", 64'(out_valid), 64'd0);
        chk("ar_count", 64'(queue_count), 64'd0);
        chk("ar_pc", pc, 64'h0);
        chk("ar_out_pc", out_pc, 64'h0);
        chk("ar_instr", 64'(out_instr), 64'(NOP));
`ifdef FETCH_PERF_CNT_EN
        chk("ar_fetch_count", 64'(fetch_count), 64'd0);
        chk("ar_stall_count", 64'(stall_count), 64'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        cyc(2);
        chk("rst_restart_pc", out_pc, 64'h0);
        chk("rst_restart_valid", 64'(out_valid), 64'd1);
        cyc(4);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
